// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: hunts for SYNC_BYTE, collects a 32-bit payload plus XOR checksum, tracks lock and errors.
// Latency: word_valid/frame_err are registered, high the cycle after the deciding bit; result captured 3 cycles after sort_finish rises.
// Backpressure: none; the serial stream is consumed one bit per t_clk unconditionally.
module serial_frame_receiver #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         ERR_CNT_W = 8
) (
    input  logic                 t_clk,
    input  logic                 rst_n,
    input  logic                 data_in,
    input  logic                 sort_finish,
    input  logic [3:0]           chip_id,
    input  logic [3:0]           power_value_upper,
    input  logic [3:0]           power_value_lower,
    output logic [31:0]          word_out,
    output logic                 word_valid,
    output logic                 locked,
    output logic                 frame_err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [11:0]          result,
    output logic                 result_valid
);

    typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK, SYNC} state_t;

    state_t      state, state_nxt;
    logic [7:0]  shift_q;
    logic [7:0]  shift_nxt;
    logic [31:0] payload_q;
    logic [5:0]  bit_cnt;
    logic [7:0]  xor_byte;
    logic        good_frame;
    logic        bad_frame;
    logic        sf_meta, sf_sync, sf_prev;
    logic        sf_rise;

    assign shift_nxt = {shift_q[6:0], data_in};
    assign xor_byte  = payload_q[31:24] ^ payload_q[23:16] ^ payload_q[15:8] ^ payload_q[7:0];
    assign sf_rise   = sf_sync & ~sf_prev;

    always_comb begin
        state_nxt  = state;
        good_frame = 1'b0;
        bad_frame  = 1'b0;
        case (state)
            // bit_cnt saturates at 7 here, so a match always needs 8 bits gathered since entry
            HUNT: begin
                if (bit_cnt >= 6'd7 && shift_nxt == SYNC_BYTE)
                    state_nxt = PAYLOAD;
            end
            PAYLOAD: begin
                if (bit_cnt == 6'd31)
                    state_nxt = CHECK;
            end
            CHECK: begin
                if (bit_cnt == 6'd7) begin
                    if (shift_nxt == xor_byte) begin
                        good_frame = 1'b1;
                        state_nxt  = SYNC;
                    end else begin
                        bad_frame = 1'b1;
                        state_nxt = HUNT;
                    end
                end
            end
            SYNC: begin
                if (bit_cnt == 6'd7) begin
                    if (shift_nxt == SYNC_BYTE) begin
                        state_nxt = PAYLOAD;
                    end else begin
                        bad_frame = 1'b1;
                        state_nxt = HUNT;
                    end
                end
            end
            default: state_nxt = HUNT;
        endcase
    end

    always_ff @(posedge t_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            shift_q   <= '0;
            payload_q <= '0;
            bit_cnt   <= '0;
        end else begin
            state   <= state_nxt;
            shift_q <= bad_frame ? 8'h00 : shift_nxt;
            if (state == PAYLOAD)
                payload_q <= {payload_q[30:0], data_in};
            if (state_nxt != state)
                bit_cnt <= '0;
            else if (state != HUNT || bit_cnt < 6'd7)
                bit_cnt <= bit_cnt + 6'd1;
        end
    end

    always_ff @(posedge t_clk or negedge rst_n) begin
        if (!rst_n) begin
            word_out   <= '0;
            word_valid <= 1'b0;
            locked     <= 1'b0;
            frame_err  <= 1'b0;
            err_cnt    <= '0;
        end else begin
            word_valid <= good_frame;
            frame_err  <= bad_frame;
            if (good_frame) begin
                word_out <= payload_q;
                locked   <= 1'b1;
            end
            if (bad_frame) begin
                locked <= 1'b0;
                if (err_cnt != {ERR_CNT_W{1'b1}})
                    err_cnt <= err_cnt + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // sort_finish comes from another domain; only its synchronized rising edge is used
    always_ff @(posedge t_clk or negedge rst_n) begin
        if (!rst_n) begin
            sf_meta      <= 1'b0;
            sf_sync      <= 1'b0;
            sf_prev      <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            sf_meta <= sort_finish;
            sf_sync <= sf_meta;
            sf_prev <= sf_sync;
            if (sf_rise) begin
                result       <= {chip_id, power_value_upper, power_value_lower};
                result_valid <= 1'b1;
            end
        end
    end

endmodule
